// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module   : uart_pkg
// Purpose  : Shared types and constants for the UART transmit queue.
//            UART_DATA_W     - width of a UART byte
//            UART_FRAME_BITS - bits per frame (start + 8 data + stop)
//            txq_state_t     - transmit sequencer states
//            uart_byte_t     - one UART byte
// Revision : 1.0 - initial release
// ============================================================================
package uart_pkg;

  localparam int UART_DATA_W     = 8;
  localparam int UART_FRAME_BITS = 10;

  typedef enum logic [1:0] {
    TXQ_IDLE  = 2'd0,
    TXQ_START = 2'd1,
    TXQ_WAIT  = 2'd2
  } txq_state_t;

  typedef logic [UART_DATA_W-1:0] uart_byte_t;

endpackage : uart_pkg
`default_nettype wire

// File: rtl/uart_sync_fifo.sv
`default_nettype none
// ============================================================================
// Module   : uart_sync_fifo
// Purpose  : Generic DEPTH x DATA_W synchronous FIFO with a separate occupancy
//            counter, count-decoded flags and a sticky overflow flag.
// Ports    : clk, reset (async, active-low)
//            wr_en/wr_data   - push side
//            rd_en/rd_data   - pop side (rd_data shows the head entry)
//            ovf_clear       - synchronous clear of overflow
//            full/empty/count/overflow - status
// Revision : 1.0 - initial release
// ============================================================================
module uart_sync_fifo #(
  parameter int DEPTH  = 8,
  parameter int DATA_W = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     wr_en,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic                     rd_en,
  output logic [DATA_W-1:0]        rd_data,
  input  logic                     ovf_clear,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow
);

  localparam int ADDR_W = $clog2(DEPTH);
  localparam logic [ADDR_W-1:0] PTR_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};
  localparam logic [ADDR_W:0]   CNT_ONE  = {{ADDR_W{1'b0}}, 1'b1};
  localparam logic [ADDR_W:0]   CNT_FULL = (ADDR_W+1)'(DEPTH);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic              overflow_q, overflow_d;
  logic              push, pop;

  assign full    = (count_q == CNT_FULL);
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign overflow = overflow_q;
  assign rd_data = mem_q[rd_ptr_q];

  always_comb begin
    pop  = rd_en && !empty;
    // A pop on the same edge frees a slot, so a push into a full FIFO is
    // still accepted when it coincides with a pop.
    push = wr_en && (!full || pop);

    wr_ptr_d   = push ? wr_ptr_q + PTR_ONE : wr_ptr_q;
    rd_ptr_d   = pop  ? rd_ptr_q + PTR_ONE : rd_ptr_q;

    count_d = count_q;
    if (push && !pop)      count_d = count_q + CNT_ONE;
    else if (pop && !push) count_d = count_q - CNT_ONE;

    // A dropped push beats a clear in the same cycle.
    overflow_d = overflow_q;
    if (wr_en && !push)  overflow_d = 1'b1;
    else if (ovf_clear)  overflow_d = 1'b0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  // Storage is not reset; contents are meaningless until written.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= wr_data;
  end

endmodule : uart_sync_fifo
`default_nettype wire

// File: rtl/uart_tx_fifo.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_fifo
// Purpose  : Byte queue plus transmit sequencer in front of a UART
//            transmitter. Pops one byte, pulses tx_start, then holds tx_data
//            until tx_done before launching the next byte.
// Ports    : clk, reset (async, active-low)
//            wr_en/wr_data          - host push
//            full/empty/count       - queue status
//            overflow/ovf_clear     - sticky dropped-push flag and its clear
//            tx_data/tx_start       - byte and launch pulse to transmitter
//            tx_done                - end-of-frame pulse from transmitter
//            tx_active              - sequencer busy (START or WAIT)
// Revision : 1.0 - initial release
// ============================================================================
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH  = 8,
  parameter int DATA_W = UART_DATA_W
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     wr_en,
  input  logic [DATA_W-1:0]        wr_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  input  logic                     ovf_clear,
  output logic [DATA_W-1:0]        tx_data,
  output logic                     tx_start,
  input  logic                     tx_done,
  output logic                     tx_active
);

  txq_state_t        state_q, state_d;
  logic [DATA_W-1:0] tx_data_q, tx_data_d;
  logic              tx_start_q, tx_start_d;
  logic              tx_active_q, tx_active_d;
  logic              pop;
  logic [DATA_W-1:0] head_data;

  uart_sync_fifo #(
    .DEPTH  (DEPTH),
    .DATA_W (DATA_W)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .wr_en     (wr_en),
    .wr_data   (wr_data),
    .rd_en     (pop),
    .rd_data   (head_data),
    .ovf_clear (ovf_clear),
    .full      (full),
    .empty     (empty),
    .count     (count),
    .overflow  (overflow)
  );

  // Outputs are computed alongside the next state so they are registered
  // and line up with the state they describe.
  always_comb begin
    state_d     = state_q;
    tx_data_d   = tx_data_q;
    tx_start_d  = 1'b0;
    tx_active_d = tx_active_q;
    pop         = 1'b0;
    case (state_q)
      TXQ_IDLE: begin
        if (!empty) begin
          pop         = 1'b1;
          tx_data_d   = head_data;
          tx_start_d  = 1'b1;
          tx_active_d = 1'b1;
          state_d     = TXQ_START;
        end
      end
      TXQ_START: begin
        tx_active_d = 1'b1;
        state_d     = TXQ_WAIT;
      end
      TXQ_WAIT: begin
        if (tx_done) begin
          tx_active_d = 1'b0;
          state_d     = TXQ_IDLE;
        end
      end
      default: begin
        tx_active_d = 1'b0;
        state_d     = TXQ_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= TXQ_IDLE;
      tx_data_q   <= '0;
      tx_start_q  <= 1'b0;
      tx_active_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      tx_data_q   <= tx_data_d;
      tx_start_q  <= tx_start_d;
      tx_active_q <= tx_active_d;
    end
  end

  assign tx_data   = tx_data_q;
  assign tx_start  = tx_start_q;
  assign tx_active = tx_active_q;

endmodule : uart_tx_fifo
`default_nettype wire

// File: tb/tb_uart_tx_fifo.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_tx_fifo
// Purpose  : Directed self-checking bench for uart_tx_fifo (DEPTH=8).
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_tx_fifo;
  import uart_pkg::*;

  logic       clk;
  logic       reset;
  logic       wr_en;
  uart_byte_t wr_data;
  logic       full;
  logic       empty;
  logic [3:0] count;
  logic       overflow;
  logic       ovf_clear;
  uart_byte_t tx_data;
  logic       tx_start;
  logic       tx_done;
  logic       tx_active;

  int n_checks = 0;
  int n_errors = 0;

  uart_tx_fifo #(
    .DEPTH  (8),
    .DATA_W (8)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .wr_en     (wr_en),
    .wr_data   (wr_data),
    .full      (full),
    .empty     (empty),
    .count     (count),
    .overflow  (overflow),
    .ovf_clear (ovf_clear),
    .tx_data   (tx_data),
    .tx_start  (tx_start),
    .tx_done   (tx_done),
    .tx_active (tx_active)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one rising edge and settle just after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    uart_byte_t drain_q[$];
    uart_byte_t cur;

    reset     = 1'b0;
    wr_en     = 1'b0;
    wr_data   = '0;
    ovf_clear = 1'b0;
    tx_done   = 1'b0;

    // ---------------- reset state ----------------
    repeat (3) tick();
    chk("rst_count",     count,     0);
    chk("rst_empty",     empty,     1);
    chk("rst_full",      full,      0);
    chk("rst_overflow",  overflow,  0);
    chk("rst_tx_start",  tx_start,  0);
    chk("rst_tx_active", tx_active, 0);
    chk("rst_tx_data",   tx_data,   0);
    reset = 1'b1;
    tick();

    // ---------------- single push, 2-cycle latency ----------------
    wr_en = 1'b1; wr_data = 8'hA5;
    tick();
    wr_en = 1'b0;
    chk("single_count1",   count,    1);
    chk("single_empty0",   empty,    0);
    chk("single_nostart",  tx_start, 0);
    tick();
    chk("single_start",    tx_start, 1);
    chk("single_data",     tx_data,  8'hA5);
    chk("single_count0",   count,    0);
    chk("single_active",   tx_active, 1);
    tick();
    chk("single_start_off", tx_start, 0);
    chk("single_active_w",  tx_active, 1);
    repeat (6) tick();
    chk("single_active_hold", tx_active, 1);
    chk("single_data_hold",   tx_data,   8'hA5);
    tx_done = 1'b1;
    tick();
    tx_done = 1'b0;
    chk("single_done_idle", tx_active, 0);
    chk("single_done_empty", empty,    1);

    // ---------------- spurious tx_done in IDLE ----------------
    tx_done = 1'b1;
    tick();
    tx_done = 1'b0;
    chk("spur_start",  tx_start,  0);
    chk("spur_active", tx_active, 0);
    tick();
    chk("spur_start2", tx_start,  0);
    chk("spur_data",   tx_data,   8'hA5);

    // ---------------- fill to full with first byte in WAIT ----------------
    // 0x01 is popped one edge after its push; 0x02..0x09 then fill all 8 slots.
    for (int i = 1; i <= 9; i++) begin
      wr_en = 1'b1; wr_data = 8'(i);
      tick();
    end
    chk("fill_count", count,     8);
    chk("fill_full",  full,      1);
    chk("fill_data",  tx_data,   8'h01);
    chk("fill_active", tx_active, 1);
    chk("fill_ovf0",  overflow,  0);

    // Push while full: dropped.
    wr_data = 8'hEE;
    tick();
    chk("ovf_set",   overflow, 1);
    chk("ovf_count", count,    8);

    // Clear in the same cycle as another dropped push: overflow stays set.
    wr_data = 8'hEF; ovf_clear = 1'b1;
    tick();
    chk("ovf_clr_vs_push", overflow, 1);
    wr_en = 1'b0;
    tick();
    ovf_clear = 1'b0;
    chk("ovf_cleared", overflow, 0);
    chk("ovf_count2",  count,    8);

    // ---------------- push and pop on the same edge while full ----------------
    tx_done = 1'b1;
    tick();
    tx_done = 1'b0;
    chk("pp_idle",  tx_active, 0);
    chk("pp_full",  full,      1);
    wr_en = 1'b1; wr_data = 8'h0A;
    tick();
    wr_en = 1'b0;
    chk("pp_count",  count,    8);
    chk("pp_ovf",    overflow, 0);
    chk("pp_start",  tx_start, 1);
    chk("pp_data",   tx_data,  8'h02);

    // ---------------- drain in order, tx_done every 10 cycles ----------------
    drain_q = '{8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'h09, 8'h0A};
    cur = 8'h02;
    foreach (drain_q[k]) begin
      repeat (8) tick();
      chk("drain_hold_start", tx_start, 0);
      chk("drain_hold_data",  tx_data,  cur);
      tx_done = 1'b1;
      tick();
      tx_done = 1'b0;
      chk("drain_idle", tx_active, 0);
      tick();
      chk("drain_start", tx_start, 1);
      chk("drain_data",  tx_data,  drain_q[k]);
      cur = drain_q[k];
    end
    repeat (8) tick();
    tx_done = 1'b1;
    tick();
    tx_done = 1'b0;
    chk("drain_end_empty", empty, 1);
    chk("drain_end_count", count, 0);
    tick();
    chk("drain_end_start",  tx_start,  0);
    chk("drain_end_active", tx_active, 0);

    // ---------------- async reset mid-WAIT with count=3 ----------------
    for (int i = 0; i < 4; i++) begin
      wr_en = 1'b1; wr_data = 8'(8'h11 + i);
      tick();
    end
    wr_en = 1'b0;
    chk("pre_rst_count",  count,     3);
    chk("pre_rst_active", tx_active, 1);
    #2;
    reset = 1'b0;
    #1;
    chk("arst_active", tx_active, 0);
    chk("arst_count",  count,     0);
    chk("arst_empty",  empty,     1);
    chk("arst_start",  tx_start,  0);
    chk("arst_data",   tx_data,   0);
    #3;
    reset = 1'b1;
    tick();
    wr_en = 1'b1; wr_data = 8'h3C;
    tick();
    wr_en = 1'b0;
    tick();
    chk("post_rst_start", tx_start, 1);
    chk("post_rst_data",  tx_data,  8'h3C);
    chk("post_rst_count", count,    0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule : tb_uart_tx_fifo
`default_nettype wire
